// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Merges the two write-back sources of the register file (port 0: execute
// result, port 1: load data) into one age-ordered circular queue. The queue
// drains one entry per cycle into registered WE3/A3/WD3 outputs. Read-after-
// write hazards are flagged for the two decode read addresses.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   req0_valid/addr/data, ready   port 0 push interface (older on a tie)
//   req1_valid/addr/data, ready   port 1 push interface
//   we, waddr, wdata              registered register-file write port
//   chk_a1, chk_a2                read addresses to test for pending writes
//   hazard1, hazard2              pending write exists for chk_a1 / chk_a2
//   idle                          queue empty and no write in flight
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  input  logic [4:0]  chk_a1,
  input  logic [4:0]  chk_a2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] wr_ptr1;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free_slots;

  logic          we_q, we_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          push0, push1, pop;
  logic          hit1, hit2;
  logic [AW-1:0] slot_off;

  // Readiness uses the registered count only; a same-cycle pop is not
  // credited, which keeps ready off the pop path and rules out overflow.
  assign free_slots = CW'(DEPTH) - count_q;
  assign req0_ready = rst && (free_slots >= CW'(1));
  assign req1_ready = rst && (free_slots >= CW'(2));

  assign push0 = req0_valid && req0_ready;
  assign push1 = req1_valid && req1_ready;
  assign pop   = (count_q != '0);

  // Port 1 lands behind port 0 when both push in the same cycle.
  assign wr_ptr1 = push0 ? (wr_ptr_q + AW'(1)) : wr_ptr_q;

  always_comb begin
    rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    wr_ptr_d = wr_ptr_q + AW'(push0) + AW'(push1);
    count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (pop) begin
      // x0 entries still drain a cycle but never assert the write enable.
      we_d    = (addr_q[rd_ptr_q] != 5'd0);
      waddr_d = addr_q[rd_ptr_q];
      wdata_d = data_q[rd_ptr_q];
    end
  end

  // Hazard search: a slot is live when its distance from the read pointer
  // (modulo DEPTH) is below the occupancy count.
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = AW'(i) - rd_ptr_q;
      if ({1'b0, slot_off} < count_q) begin
        if (addr_q[i] == chk_a1) hit1 = 1'b1;
        if (addr_q[i] == chk_a2) hit2 = 1'b1;
      end
    end
  end

  assign hazard1 = (chk_a1 != 5'd0) && (hit1 || (we_q && (waddr_q == chk_a1)));
  assign hazard2 = (chk_a2 != 5'd0) && (hit2 || (we_q && (waddr_q == chk_a2)));
  assign idle    = (count_q == '0) && !we_q;

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

  // Queue payload needs no reset: only slots inside the count are ever read.
  always_ff @(posedge clk) begin
    if (push0) begin
      addr_q[wr_ptr_q] <= req0_addr;
      data_q[wr_ptr_q] <= req0_data;
    end
    if (push1) begin
      addr_q[wr_ptr1] <= req1_addr;
      data_q[wr_ptr1] <= req1_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter (DEPTH=4). Inputs change and outputs
// are sampled on the falling clock edge, away from the rising active edge.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_addr = '0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_addr = '0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  chk_a1 = '0;
  logic [4:0]  chk_a2 = '0;
  logic        hazard1, hazard2, idle;

  int pass_cnt  = 0;
  int total_cnt = 0;

  regfile_wb_arbiter #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .chk_a1     (chk_a1),
    .chk_a2     (chk_a2),
    .hazard1    (hazard1),
    .hazard2    (hazard2),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    total_cnt++; if (we !== 1'b0) $display("FAIL rst_we got=%0b exp=0", we); else pass_cnt++;
    total_cnt++; if (req0_ready !== 1'b0) $display("FAIL rst_ready0 got=%0b exp=0", req0_ready); else pass_cnt++;
    total_cnt++; if (req1_ready !== 1'b0) $display("FAIL rst_ready1 got=%0b exp=0", req1_ready); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1) $display("FAIL rst_idle got=%0b exp=1", idle); else pass_cnt++;
    total_cnt++; if (hazard1 !== 1'b0) $display("FAIL rst_hazard1 got=%0b exp=0", hazard1); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++; if (req0_ready !== 1'b1) $display("FAIL rel_ready0 got=%0b exp=1", req0_ready); else pass_cnt++;
    total_cnt++; if (req1_ready !== 1'b1) $display("FAIL rel_ready1 got=%0b exp=1", req1_ready); else pass_cnt++;
  endtask

  task automatic test_single_push();
    @(negedge clk);
    chk_a1 = 5'd5; chk_a2 = 5'd6;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    @(negedge clk);  // edge N pushed
    req0_valid = 1'b0;
    total_cnt++; if (we !== 1'b0) $display("FAIL sp_we_n got=%0b exp=0", we); else pass_cnt++;
    total_cnt++; if (hazard1 !== 1'b1) $display("FAIL sp_haz1_n got=%0b exp=1", hazard1); else pass_cnt++;
    total_cnt++; if (hazard2 !== 1'b0) $display("FAIL sp_haz2_n got=%0b exp=0", hazard2); else pass_cnt++;
    total_cnt++; if (idle !== 1'b0) $display("FAIL sp_idle_n got=%0b exp=0", idle); else pass_cnt++;
    @(negedge clk);  // edge N+1 popped
    total_cnt++; if (we !== 1'b1) $display("FAIL sp_we got=%0b exp=1", we); else pass_cnt++;
    total_cnt++; if (waddr !== 5'd5) $display("FAIL sp_waddr got=%0d exp=5", waddr); else pass_cnt++;
    total_cnt++; if (wdata !== 32'hDEADBEEF) $display("FAIL sp_wdata got=%h exp=deadbeef", wdata); else pass_cnt++;
    total_cnt++; if (hazard1 !== 1'b1) $display("FAIL sp_haz1_w got=%0b exp=1", hazard1); else pass_cnt++;
    @(negedge clk);  // edge N+2
    total_cnt++; if (we !== 1'b0) $display("FAIL sp_we_end got=%0b exp=0", we); else pass_cnt++;
    total_cnt++; if (hazard1 !== 1'b0) $display("FAIL sp_haz1_end got=%0b exp=0", hazard1); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1) $display("FAIL sp_idle_end got=%0b exp=1", idle); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    chk_a1 = 5'd3; chk_a2 = 5'd0;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h22;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    total_cnt++; if (hazard1 !== 1'b1) $display("FAIL sim_haz1_n got=%0b exp=1", hazard1); else pass_cnt++;
    total_cnt++; if (we !== 1'b0) $display("FAIL sim_we_n got=%0b exp=0", we); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({we, waddr, wdata} !== {1'b1, 5'd3, 32'h11}) $display("FAIL sim_first got=%0b/%0d/%h exp=1/3/11", we, waddr, wdata); else pass_cnt++;
    total_cnt++; if (hazard1 !== 1'b1) $display("FAIL sim_haz1_a got=%0b exp=1", hazard1); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({we, waddr, wdata} !== {1'b1, 5'd3, 32'h22}) $display("FAIL sim_second got=%0b/%0d/%h exp=1/3/22", we, waddr, wdata); else pass_cnt++;
    total_cnt++; if (hazard1 !== 1'b1) $display("FAIL sim_haz1_b got=%0b exp=1", hazard1); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (we !== 1'b0) $display("FAIL sim_we_end got=%0b exp=0", we); else pass_cnt++;
    total_cnt++; if (hazard1 !== 1'b0) $display("FAIL sim_haz1_end got=%0b exp=0", hazard1); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1) $display("FAIL sim_idle_end got=%0b exp=1", idle); else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [36:0] exp_q[$];
    logic [36:0] head;
    logic        exp_r1 [6];
    int          commits;
    // count before each edge: 0, 2, 3, 3, 3, 3 -> port 1 ready only twice
    exp_r1 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    commits = 0;
    chk_a1 = 5'd0;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1; req0_addr = 5'(1 + 2 * i); req0_data = 32'h0A00 + 32'(i);
      req1_valid = 1'b1; req1_addr = 5'(2 + 2 * i); req1_data = 32'h0B00 + 32'(i);
      #1;
      total_cnt++; if (req0_ready !== 1'b1) $display("FAIL fill_ready0[%0d] got=%0b exp=1", i, req0_ready); else pass_cnt++;
      total_cnt++; if (req1_ready !== exp_r1[i]) $display("FAIL fill_ready1[%0d] got=%0b exp=%0b", i, req1_ready, exp_r1[i]); else pass_cnt++;
      exp_q.push_back({req0_addr, req0_data});
      if (exp_r1[i]) exp_q.push_back({req1_addr, req1_data});
      @(negedge clk);
      if (we) begin
        commits++;
        head = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h0;
        total_cnt++; if ({waddr, wdata} !== head) $display("FAIL fill_commit got=%0d/%h exp=%0d/%h", waddr, wdata, head[36:32], head[31:0]); else pass_cnt++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (we) begin
        commits++;
        head = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h0;
        total_cnt++; if ({waddr, wdata} !== head) $display("FAIL fill_commit got=%0d/%h exp=%0d/%h", waddr, wdata, head[36:32], head[31:0]); else pass_cnt++;
      end
      if (idle) break;
    end
    total_cnt++; if (commits != 8) $display("FAIL fill_count got=%0d exp=8", commits); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1) $display("FAIL fill_drain_timeout idle=%0b exp=1", idle); else pass_cnt++;
  endtask

  task automatic test_x0();
    chk_a1 = 5'd0;
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
    @(negedge clk);
    req1_valid = 1'b0;
    total_cnt++; if (idle !== 1'b0) $display("FAIL x0_idle_n got=%0b exp=0", idle); else pass_cnt++;
    total_cnt++; if (hazard1 !== 1'b0) $display("FAIL x0_haz1_n got=%0b exp=0", hazard1); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (we !== 1'b0) $display("FAIL x0_we got=%0b exp=0", we); else pass_cnt++;
    total_cnt++; if (wdata !== 32'hFFFFFFFF) $display("FAIL x0_wdata got=%h exp=ffffffff", wdata); else pass_cnt++;
    total_cnt++; if (hazard1 !== 1'b0) $display("FAIL x0_haz1 got=%0b exp=0", hazard1); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1) $display("FAIL x0_idle got=%0b exp=1", idle); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int stale;
    stale = 0;
    chk_a1 = 5'd8;
    req0_valid = 1'b1; req0_addr = 5'd7;  req0_data = 32'h70;
    req1_valid = 1'b1; req1_addr = 5'd8;  req1_data = 32'h80;
    @(negedge clk);
    req0_addr = 5'd9;  req0_data = 32'h90;
    req1_addr = 5'd10; req1_data = 32'hA0;
    @(negedge clk);  // three entries queued, x7 in flight
    req0_valid = 1'b0; req1_valid = 1'b0;
    total_cnt++; if ({we, waddr} !== {1'b1, 5'd7}) $display("FAIL ar_pre got=%0b/%0d exp=1/7", we, waddr); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (we !== 1'b0) $display("FAIL ar_we got=%0b exp=0", we); else pass_cnt++;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL ar_ready got=%b exp=00", {req0_ready, req1_ready}); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1) $display("FAIL ar_idle got=%0b exp=1", idle); else pass_cnt++;
    total_cnt++; if (hazard1 !== 1'b0) $display("FAIL ar_haz1 got=%0b exp=0", hazard1); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b11) $display("FAIL ar_rel_ready got=%b exp=11", {req0_ready, req1_ready}); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (we !== 1'b0) stale++;
    end
    total_cnt++; if (stale != 0) $display("FAIL ar_stale got=%0d exp=0", stale); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1) $display("FAIL ar_idle_after got=%0b exp=1", idle); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_simultaneous();
    test_fill();
    test_x0();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
